// File: rtl/noc_output_arbiter.sv
// Purpose : round-robin, packet-locked (wormhole) arbiter sharing one four-phase req/ack output link among NUM_IN inputs.
// Latency : out_req rises one clock after the winning in_req is sampled; each flit then follows the four-phase handshake.
// Backpres: a stalled out_ack holds out_req/out_data steady and withholds in_ack; losing inputs wait unacknowledged.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_req/in_ack     per-input four-phase handshake; in_ack is one-hot (granted input) or zero
//   in_data           NUM_IN flits, input i at [i*n +: n]
//   out_req/out_ack   downstream four-phase handshake
//   out_data          registered flit presented downstream
//   grant_idx, busy   granted input and packet-in-progress flag
module noc_output_arbiter #(
    parameter int n       = 32,
    parameter int NUM_IN  = 4,
    parameter int LEN_LSB = 0,
    parameter int LEN_W   = 8,
    localparam int IDXW   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IN-1:0]     in_req,
    output logic [NUM_IN-1:0]     in_ack,
    input  logic [NUM_IN*n-1:0]   in_data,
    output logic                  out_req,
    input  logic                  out_ack,
    output logic [n-1:0]          out_data,
    output logic [IDXW-1:0]       grant_idx,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        XFER      = 3'd1,
        ACK_SRC   = 3'd2,
        RELEASE   = 3'd3,
        WAIT_FLIT = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [IDXW-1:0]     rr_ptr, rr_nxt;
    logic [LEN_W-1:0]    flits_left, flits_nxt;
    logic [IDXW-1:0]     grant_nxt;
    logic [n-1:0]        data_nxt;

    logic                win_found;
    logic [IDXW-1:0]     win_idx;
    logic [n-1:0]        win_flit;
    logic [n-1:0]        gnt_flit;
    logic [NUM_IN-1:0]   ack_nxt;
    int                  scan_idx;

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_IN;
            if (!win_found && in_req[IDXW'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(scan_idx);
            end
        end
    end

    // Flit muxes for the arbitration winner (header) and the locked grant (body).
    always_comb begin
        win_flit = '0;
        gnt_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (IDXW'(i) == win_idx)   win_flit = in_data[i*n +: n];
            if (IDXW'(i) == grant_idx) gnt_flit = in_data[i*n +: n];
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_idx;
        data_nxt  = out_data;
        flits_nxt = flits_left;
        rr_nxt    = rr_ptr;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = XFER;
                    grant_nxt = win_idx;
                    data_nxt  = win_flit;
                    flits_nxt = win_flit[LEN_LSB +: LEN_W];
                end
            end
            XFER: begin
                if (out_ack) state_nxt = ACK_SRC;
            end
            ACK_SRC: begin
                if (!in_req[grant_idx]) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!out_ack) begin
                    if (flits_left == '0) begin
                        state_nxt = IDLE;
                        rr_nxt    = (grant_idx == IDXW'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
                    end else begin
                        state_nxt = WAIT_FLIT;
                        flits_nxt = flits_left - 1'b1;
                    end
                end
            end
            WAIT_FLIT: begin
                // Body flits are forwarded verbatim; other inputs are ignored.
                if (in_req[grant_idx]) begin
                    state_nxt = XFER;
                    data_nxt  = gnt_flit;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they never glitch.
    always_comb begin
        ack_nxt = '0;
        if (state_nxt == ACK_SRC || state_nxt == RELEASE) begin
            for (int i = 0; i < NUM_IN; i++) begin
                ack_nxt[i] = (IDXW'(i) == grant_nxt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_idx  <= '0;
            out_data   <= '0;
            flits_left <= '0;
            rr_ptr     <= '0;
            out_req    <= 1'b0;
            in_ack     <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_idx  <= grant_nxt;
            out_data   <= data_nxt;
            flits_left <= flits_nxt;
            rr_ptr     <= rr_nxt;
            out_req    <= (state_nxt == XFER) || (state_nxt == ACK_SRC);
            in_ack     <= ack_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Purpose : directed self-checking bench for noc_output_arbiter (4 inputs, 32-bit flits, 8-bit LEN).
// Latency : inputs driven and outputs sampled 1ns after each rising edge.
// Backpres: the bench plays both source and sink sides of the four-phase handshake.
module tb_noc_output_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_req;
    logic [3:0]   in_ack;
    logic [127:0] in_data;
    logic         out_req;
    logic         out_ack;
    logic [31:0]  out_data;
    logic [1:0]   grant_idx;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    noc_output_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .in_req    (in_req),
        .in_ack    (in_ack),
        .in_data   (in_data),
        .out_req   (out_req),
        .out_ack   (out_ack),
        .out_data  (out_data),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered with the DUT in XFER for input g; completes one flit handshake.
    task automatic xfer_flit(input int g, input logic [31:0] exp, input bit last);
        chk("xfer_out_req", 32'(out_req), 32'd1);
        chk("xfer_out_data", out_data, exp);
        chk("xfer_grant", 32'(grant_idx), 32'(g));
        chk("xfer_no_ack", 32'(in_ack), 32'd0);
        out_ack = 1'b1;
        tick();
        chk("acksrc_in_ack", 32'(in_ack), 32'(1 << g));
        chk("acksrc_out_req", 32'(out_req), 32'd1);
        in_req[g] = 1'b0;
        tick();
        chk("release_out_req", 32'(out_req), 32'd0);
        chk("release_in_ack", 32'(in_ack), 32'(1 << g));
        out_ack = 1'b0;
        tick();
        chk("done_in_ack", 32'(in_ack), 32'd0);
        chk("done_busy", 32'(busy), 32'(!last));
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        in_req  = '0;
        out_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        in_req  = '0;
        in_data = '0;
        out_ack = 1'b0;

        // Reset state
        do_reset();
        chk("rst_out_req", 32'(out_req), 32'd0);
        chk("rst_in_ack", 32'(in_ack), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("rst_flits_left", 32'(dut.flits_left), 32'd0);

        // Single header-only packet from input 0
        in_data[0 +: 32] = 32'hA5A5_0000;
        in_req[0] = 1'b1;
        chk("t1_latency", 32'(out_req), 32'd0);
        tick();
        chk("t1_busy", 32'(busy), 32'd1);
        xfer_flit(0, 32'hA5A5_0000, 1'b1);
        chk("t1_rr_ptr", 32'(dut.rr_ptr), 32'd1);

        // All four request together from rr_ptr=0: served 0,1,2,3
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'(i) << 16;
        in_req = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            xfer_flit(i, 32'(i) << 16, 1'b1);
        end
        chk("t2_rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // Input 2 sends 4 flits; input 1 requests during flit 2 and must wait
        in_data[64 +: 32] = 32'h0000_0003;
        in_req[2] = 1'b1;
        tick();
        xfer_flit(2, 32'h0000_0003, 1'b0);
        chk("t3_flits_left", 32'(dut.flits_left), 32'd2);
        in_data[64 +: 32] = 32'h11;
        in_req[2] = 1'b1;
        tick();
        xfer_flit(2, 32'h11, 1'b0);
        in_data[32 +: 32] = 32'h0001_0000;
        in_req[1] = 1'b1;
        in_data[64 +: 32] = 32'h22;
        in_req[2] = 1'b1;
        tick();
        xfer_flit(2, 32'h22, 1'b0);
        in_data[64 +: 32] = 32'h33;
        in_req[2] = 1'b1;
        tick();
        xfer_flit(2, 32'h33, 1'b1);
        chk("t3_rr_ptr", 32'(dut.rr_ptr), 32'd3);
        tick();
        xfer_flit(1, 32'h0001_0000, 1'b1);
        chk("t3_rr_ptr2", 32'(dut.rr_ptr), 32'd2);

        // Maximum length packet from input 0 (rr_ptr=2 scans 2,3,0)
        in_data[0 +: 32] = 32'h0000_00FF;
        in_req[0] = 1'b1;
        tick();
        chk("t4_flits_hdr", 32'(dut.flits_left), 32'd255);
        xfer_flit(0, 32'h0000_00FF, 1'b0);
        chk("t4_flits_after_hdr", 32'(dut.flits_left), 32'd254);
        for (int k = 1; k <= 255; k++) begin
            in_data[0 +: 32] = 32'(k) | 32'hBEEF_0000;
            in_req[0] = 1'b1;
            tick();
            xfer_flit(0, 32'(k) | 32'hBEEF_0000, k == 255);
        end
        chk("t4_flits_end", 32'(dut.flits_left), 32'd0);
        chk("t4_rr_ptr", 32'(dut.rr_ptr), 32'd1);

        // Reset pulsed in ACK_SRC; input 3 keeps requesting and is re-granted
        in_data[96 +: 32] = 32'h0000_3000;
        in_req[3] = 1'b1;
        tick();
        chk("t5_grant", 32'(grant_idx), 32'd3);
        out_ack = 1'b1;
        tick();
        chk("t5_acksrc", 32'(in_ack), 32'h8);
        rst = 1'b1;
        out_ack = 1'b0;
        tick();
        chk("t5_rst_out_req", 32'(out_req), 32'd0);
        chk("t5_rst_in_ack", 32'(in_ack), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        rst = 1'b0;
        tick();
        xfer_flit(3, 32'h0000_3000, 1'b1);
        chk("t5_rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // Downstream stalled for 50 cycles
        in_data[32 +: 32] = 32'h0BAD_0000;
        in_req[1] = 1'b1;
        tick();
        for (int c = 0; c < 50; c++) begin
            tick();
            chk("t6_stall_out_req", 32'(out_req), 32'd1);
            chk("t6_stall_data", out_data, 32'h0BAD_0000);
            chk("t6_stall_in_ack", 32'(in_ack), 32'd0);
        end
        xfer_flit(1, 32'h0BAD_0000, 1'b1);

        // out_ack in IDLE with no request is ignored
        out_ack = 1'b1;
        tick();
        tick();
        chk("t7_idle_busy", 32'(busy), 32'd0);
        chk("t7_idle_out_req", 32'(out_req), 32'd0);
        chk("t7_idle_in_ack", 32'(in_ack), 32'd0);
        out_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
